// File: rtl/parking_lane_arbiter.sv
// parking_lane_arbiter: round-robin sharing of one PIN checker and gate sequencer between two entry lanes
module parking_lane_arbiter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [8:0]       pin_a,
  input  logic [8:0]       pin_b,
  input  logic             passed_a,
  input  logic             passed_b,
  input  logic             exit_evt,
  input  logic             chk_done,
  input  logic             chk_ok,
  output logic             chk_valid,
  output logic [8:0]       chk_pin,
  output logic             grant_a,
  output logic             grant_b,
  output logic             open_a,
  output logic             open_b,
  output logic [CNT_W-1:0] occupancy,
  output logic             full
);
  typedef enum logic [1:0] {IDLE, CHECK, OPEN} state_t;
  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic prio_q, prio_d, lane_q, lane_d, inc, dec, req_g, passed_g;
  logic [7:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  assign req_g    = lane_q ? req_b : req_a;
  assign passed_g = lane_q ? passed_b : passed_a;
  assign dec      = exit_evt && occ_q != '0;
  // every output is decoded from flops so reset clears them at once
  assign full      = occ_q == CNT_W'(CAPACITY);
  assign occupancy = occ_q;
  assign chk_valid = state_q == CHECK;
  assign chk_pin   = state_q == CHECK ? (lane_q ? pin_b : pin_a) : '0;
  assign grant_a   = state_q != IDLE && !lane_q;
  assign grant_b   = state_q != IDLE && lane_q;
  assign open_a    = state_q == OPEN && !lane_q;
  assign open_b    = state_q == OPEN && lane_q;
  // lane sequencing: pick winner, verify PIN, hold gate open until pass or timeout
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    lane_d  = lane_q;
    tmr_d   = tmr_q;
    inc     = 1'b0;
    case (state_q)
      IDLE: if (!full && (req_a || req_b)) begin
        lane_d  = (req_a && req_b) ? prio_q : req_b;
        state_d = CHECK;
      end
      CHECK: if (chk_done) begin
        state_d = chk_ok ? OPEN : IDLE;
        prio_d  = chk_ok ? prio_q : ~lane_q;
        tmr_d   = '0;
      end else if (!req_g) begin
        state_d = IDLE;
        prio_d  = ~lane_q;
      end
      OPEN: begin
        tmr_d = tmr_q + 8'd1;
        if (passed_g || tmr_q == TMR_LAST) begin
          state_d = IDLE;
          prio_d  = ~lane_q;
          inc     = passed_g;
        end
      end
      default: state_d = IDLE;
    endcase
    occ_d = (inc && !dec) ? occ_q + 1'b1 : (dec && !inc) ? occ_q - 1'b1 : occ_q;
  end
  // state, round-robin pointer, gate timer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      lane_q  <= 1'b0;
      tmr_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lane_q  <= lane_d;
      tmr_q   <= tmr_d;
      occ_q   <= occ_d;
    end
  end
endmodule

// File: tb/tb_parking_lane_arbiter.sv
// tb_parking_lane_arbiter: scoreboard-driven check of lane arbitration, gate sequencing and occupancy
module tb_parking_lane_arbiter;
  localparam int CAP = 2, TMO = 15, CW = 4;
  logic clk = 0, rst = 0, req_a = 0, req_b = 0, passed_a = 0, passed_b = 0;
  logic exit_evt = 0, chk_done = 0, chk_ok = 0;
  logic [8:0] pin_a = 9'h1a5, pin_b = 9'h04c;
  logic chk_valid, grant_a, grant_b, open_a, open_b, full;
  logic [8:0] chk_pin;
  logic [CW-1:0] occupancy;
  int n_cmp = 0, n_err = 0, exp_occ = 0;
  logic [1:0] gq[$];
  logic [1:0] g_prev;
  parking_lane_arbiter #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .pin_a(pin_a), .pin_b(pin_b),
    .passed_a(passed_a), .passed_b(passed_b), .exit_evt(exit_evt), .chk_done(chk_done),
    .chk_ok(chk_ok), .chk_valid(chk_valid), .chk_pin(chk_pin), .grant_a(grant_a),
    .grant_b(grant_b), .open_a(open_a), .open_b(open_b), .occupancy(occupancy), .full(full)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // pops the expected lane every time a fresh grant appears
  always @(negedge clk) begin
    if (!rst) g_prev = 2'b00;
    else begin
      if ({grant_b, grant_a} != 2'b00 && g_prev == 2'b00) begin
        if (gq.size() == 0) check("grant_unexpected", {grant_b, grant_a}, 0);
        else check("grant_order", {grant_b, grant_a}, gq.pop_front());
      end
      if (open_a || open_b) check("open_overlap", open_a & open_b, 0);
      g_prev = {grant_b, grant_a};
    end
  end
  task automatic run_entry(input bit lane, input bit ok, input int hold, input bit drop, input bit ex);
    int n, cnt;
    n = 0;
    while (!(grant_a || grant_b) && n < 40) begin cyc(); n++; end
    check("grant_wait", n < 40, 1);
    check("chk_valid_hi", chk_valid, 1);
    check("chk_pin", chk_pin, lane ? pin_b : pin_a);
    chk_done = 1; chk_ok = ok;
    cyc();
    chk_done = 0; chk_ok = 0;
    check("chk_valid_lo", chk_valid, 0);
    check("open_after_chk", lane ? open_b : open_a, ok);
    if (!ok) begin
      if (drop) begin req_a = 0; req_b = 0; end
      check("grant_rel_fail", grant_a | grant_b, 0);
    end else begin
      cnt = 1;
      if (hold == 0) begin
        if (drop) begin req_a = 0; req_b = 0; end
        n = 0;
        while ((lane ? open_b : open_a) && n < 40) begin
          cyc(); n++;
          if (lane ? open_b : open_a) cnt++;
        end
        check("open_timeout_cycles", cnt, TMO);
      end else begin
        repeat (hold - 1) begin cyc(); if (lane ? open_b : open_a) cnt++; end
        if (lane) passed_b = 1; else passed_a = 1;
        if (drop) begin req_a = 0; req_b = 0; end
        exit_evt = ex;
        cyc();
        passed_a = 0; passed_b = 0; exit_evt = 0;
        if (!ex) exp_occ++;
        check("open_cycles", cnt, hold);
        check("open_lo", open_a | open_b, 0);
        check("grant_lo", grant_a | grant_b, 0);
      end
    end
    check("occupancy", occupancy, exp_occ);
    check("full", full, exp_occ == CAP);
  endtask
  task automatic exit_pulse();
    exit_evt = 1;
    cyc();
    exit_evt = 0;
    if (exp_occ > 0) exp_occ--;
    check("occ_after_exit", occupancy, exp_occ);
    check("full_after_exit", full, exp_occ == CAP);
  endtask
  initial begin
    #3;
    check("rst_outputs", {chk_valid, grant_a, grant_b, open_a, open_b, full}, 0);
    check("rst_occ", occupancy, 0);
    check("rst_pin", chk_pin, 0);
    cyc();
    rst = 1;
    cyc();
    req_a = 1; gq.push_back(2'b01);
    run_entry(0, 1, 3, 1, 0);
    exit_pulse();
    req_a = 1; req_b = 1;
    gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01);
    for (int i = 0; i < 4; i++) begin
      run_entry(i[0] ? 1'b0 : 1'b1, 1, 2, i == 3, 0);
      exit_pulse();
    end
    req_a = 1; gq.push_back(2'b01);
    cyc();
    req_b = 1; gq.push_back(2'b10);
    run_entry(0, 0, 0, 0, 0);
    run_entry(1, 1, 2, 1, 0);
    req_a = 1; gq.push_back(2'b01);
    run_entry(0, 1, 2, 1, 1);
    req_b = 1; gq.push_back(2'b10);
    run_entry(1, 1, 1, 1, 0);
    req_a = 1; gq.push_back(2'b01);
    repeat (5) cyc();
    check("full_blocks_grant", {grant_a, chk_valid}, 0);
    exit_pulse();
    run_entry(0, 1, 0, 1, 0);
    req_b = 1; gq.push_back(2'b10);
    cyc();
    check("abort_granted", grant_b, 1);
    req_b = 0;
    cyc();
    check("abort_release", {grant_b, chk_valid}, 0);
    req_a = 1; gq.push_back(2'b01);
    cyc(); cyc();
    check("pre_rst_grant", grant_a, 1);
    chk_done = 1; chk_ok = 1;
    cyc();
    chk_done = 0; chk_ok = 0;
    check("pre_rst_open", open_a, 1);
    check("pre_rst_occ", occupancy, 1);
    #2 rst = 0;
    #1;
    check("rst_open", {open_a, grant_a, chk_valid, full}, 0);
    check("rst_occ_mid", occupancy, 0);
    req_a = 0; exp_occ = 0;
    rst = 1;
    exit_pulse();
    check("idle_after_rst", grant_a | grant_b, 0);
    check("sb_empty", gq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/parking_lane_arbiter.md
# parking_lane_arbiter

Two-lane entry scheduler for the parking controller. It shares one PIN-verification unit between lane A and lane B, grants it round-robin, and sequences the granted lane's gate through check, open and pass. It tracks lot occupancy and refuses new entries when the lot is full. It sits between the per-lane sensors and keypads and the single PIN checker / gate drivers.

## Interface
- CAPACITY, 8, maximum cars in the lot (1..15)
- CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > CAPACITY
- TIMEOUT, 15, cycles the gate stays open waiting for the car to pass (1..255)

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- req_a, req_b  in  1  level; car present at lane entry sensor
- pin_a, pin_b  in  9  keypad PIN of each lane
- passed_a, passed_b  in  1  car has passed the gate of that lane
- exit_evt  in  1  one-cycle pulse; a car left the lot
- chk_done  in  1  one-cycle pulse from the PIN checker; result valid
- chk_ok  in  1  PIN correct; qualified by chk_done
- chk_valid  out  1  request to the PIN checker
- chk_pin  out  9  PIN presented to the checker
- grant_a, grant_b  out  1  lane owns the checker/gate (one-hot or zero)
- open_a, open_b  out  1  gate-open command (level)
- occupancy  out  CNT_W  cars currently inside
- full  out  1  occupancy == CAPACITY

## Operation
- States: IDLE, CHECK, OPEN. Reset state is IDLE.
- Priority pointer `prio` resets to lane A.
- IDLE:
  - If !full and any req: the winner is the `prio` lane when both lanes request, otherwise the requesting lane.
  - Latch the winner, assert its grant, go to CHECK.
  - If full, all requests wait; no grant is issued.
- CHECK:
  - chk_valid=1; chk_pin = PIN of the granted lane (live, muxed by grant).
  - chk_done & chk_ok: go to OPEN.
  - chk_done & !chk_ok: go to IDLE, release grant, `prio` set to the other lane.
  - Granted req drops before chk_done: abort to IDLE, release grant, `prio` set to the other lane.
- OPEN:
  - open_x=1 for the granted lane; the timeout counter loads 0 on entry and increments each cycle.
  - passed_x: go to IDLE, occupancy +1, release grant, `prio` set to the other lane.
  - Counter reaches TIMEOUT-1 without passed_x: go to IDLE, no increment, `prio` set to the other lane.
  - passed on the non-granted lane is ignored.
- Occupancy rules:
  - Decrement on exit_evt; exit_evt at occupancy 0 is ignored.
  - Increment and decrement in the same cycle leave occupancy unchanged.
  - Never exceeds CAPACITY, since grants are blocked when full.
- Only one gate may be open at any time; grant_a & grant_b is never 1.

## Timing
- Reset (asynchronous, immediate): state IDLE, prio=A, grants 0, open 0, chk_valid 0, chk_pin 0, occupancy 0, full 0. Reset asserted mid-CHECK or mid-OPEN drops every output in the same instant.
- All outputs are registered. A request sampled at edge N gives grant and chk_valid high after edge N.
- chk_done sampled at edge M gives chk_valid low and open_x high after edge M.
- passed_x sampled at edge P gives open_x and grant low and occupancy updated after edge P. full updates in the same cycle as occupancy.
- A new grant can issue at the edge after returning to IDLE, giving a minimum one-cycle gap between grants.
- Timeout: open_x is high for exactly TIMEOUT cycles when the car never passes.

## Test plan
- Reset, then req_a=1, chk_done&chk_ok one cycle after chk_valid, passed_a 3 cycles later -> grant_a, chk_pin=pin_a, open_a high 3 cycles, occupancy=1.
- req_a=req_b=1 continuously with all PINs correct and passes prompt -> grants alternate A,B,A,B; open_a and open_b never overlap.
- chk_done with chk_ok=0 on lane A while req_b pending -> back to IDLE, next grant goes to B; occupancy unchanged.
- CAPACITY=2: two successful entries -> full=1, further req_a ignored. Then exit_evt -> occupancy=1, full=0, grant issued.
- Gate opened, passed never asserted, TIMEOUT=15 -> open high exactly 15 cycles, occupancy unchanged. Separately, passed_a coincident with exit_evt at occupancy 1 -> occupancy stays 1.
- rst low during OPEN -> open, grant and occupancy all 0 immediately. exit_evt at occupancy 0 -> stays 0.
